// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory model.
// Nibble, counter, command and state encodings used by the responder.
package idli_pkg;

  typedef logic [3:0] slice_t;
  typedef logic [1:0] ctr_t;

  localparam int ADDR_W            = 16;
  localparam int SQI_ADDR_NIBBLES  = ADDR_W / 4;
  localparam int SQI_DUMMY_NIBBLES = 2;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, SKIP
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Byte-wide storage behind the SQI responder: one synchronous write port
// and one combinational read port, so a vendor RAM can drop in here.
module idli_sqi_ram_m #(
  parameter int DEPTH = 65536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Contents are deliberately not reset; preload happens via the write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI responder emulating a 23LC-style serial SRAM in sequential mode.
// One nibble per i_clk edge while chip select is low; backdoor write for preload.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sqi_cs_n,
  input  slice_t            i_sqi_sio,
  output slice_t            o_sqi_sio,
  output logic              o_sqi_oe,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [7:0]        i_dbg_data,
  output logic              o_busy
);

  localparam int AW = $clog2(DEPTH);

  sqi_state_t    r_state;
  ctr_t          r_ctr;
  logic [7:0]    r_cmd;
  logic [AW-1:0] r_addr;
  slice_t        r_wnib;

  logic          w_sqi_we, w_we, w_oe, w_unused_dbg;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata, w_rdata;

  assign w_unused_dbg = ^i_dbg_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ctr   <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_wnib  <= '0;
    end else if (i_sqi_cs_n) begin
      r_state <= IDLE;
      r_ctr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd   <= {4'h0, i_sqi_sio};
          r_state <= CMD;
        end
        CMD: begin
          r_cmd   <= {r_cmd[3:0], i_sqi_sio};
          r_ctr   <= '0;
          r_state <= ADDR;
        end
        ADDR: begin
          // Shifting into an AW-bit register keeps only the in-range address bits.
          r_addr <= AW'({r_addr, i_sqi_sio});
          r_ctr  <= r_ctr + 2'd1;
          if (r_ctr == ctr_t'(SQI_ADDR_NIBBLES - 1)) begin
            r_ctr <= '0;
            case (r_cmd)
              SQI_CMD_READ:  r_state <= DUMMY;
              SQI_CMD_WRITE: r_state <= WDATA;
              default:       r_state <= SKIP;
            endcase
          end
        end
        DUMMY: begin
          r_ctr <= r_ctr + 2'd1;
          if (r_ctr == ctr_t'(SQI_DUMMY_NIBBLES - 1)) begin
            r_ctr   <= '0;
            r_state <= RDATA;
          end
        end
        RDATA, WDATA: begin
          // ctr[0] selects high (0) or low (1) nibble; address moves after the low one.
          if (r_state == WDATA && !r_ctr[0]) r_wnib <= i_sqi_sio;
          r_ctr <= {1'b0, ~r_ctr[0]};
          if (r_ctr[0]) r_addr <= r_addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_sqi_we = (r_state == WDATA) && !i_sqi_cs_n && r_ctr[0];
  assign w_we     = w_sqi_we || (i_dbg_we && i_sqi_cs_n);
  assign w_waddr  = w_sqi_we ? r_addr : i_dbg_addr[AW-1:0];
  assign w_wdata  = w_sqi_we ? {r_wnib, i_sqi_sio} : i_dbg_data;

  idli_sqi_ram_m #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(r_addr),
    .o_rdata(w_rdata)
  );

  // Output enable follows cs_n combinationally so release is contention-free.
  assign w_oe      = (r_state == RDATA) && !i_sqi_cs_n;
  assign o_sqi_oe  = w_oe;
  assign o_sqi_sio = w_oe ? (r_ctr[0] ? w_rdata[3:0] : w_rdata[7:4]) : '0;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed plus randomized bench for idli_sqi_mem_m against a byte-array model.
module tb_idli_sqi_mem_m;
  localparam int DEPTH = 256;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_sqi_cs_n, i_dbg_we;
  logic [3:0]  i_sqi_sio, o_sqi_sio;
  logic        o_sqi_oe, o_busy;
  logic [15:0] i_dbg_addr;
  logic [7:0]  i_dbg_data;

  logic [7:0]  mem_m [DEPTH];
  logic [3:0]  dat [64];
  int tests = 0, fails = 0;

  always #5 i_clk = ~i_clk;

  idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sqi_cs_n(i_sqi_cs_n),
    .i_sqi_sio (i_sqi_sio),
    .o_sqi_sio (o_sqi_sio),
    .o_sqi_oe  (o_sqi_oe),
    .i_dbg_we  (i_dbg_we),
    .i_dbg_addr(i_dbg_addr),
    .i_dbg_data(i_dbg_data),
    .o_busy    (o_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SQI clock: drive inputs just after an edge, return 1ns after the next edge.
  task automatic step(input logic cs, input logic [3:0] nib);
    i_sqi_cs_n = cs;
    i_sqi_sio  = nib;
    @(posedge i_clk); #1;
  endtask

  task automatic bd(input logic [15:0] a, input logic [7:0] d);
    i_dbg_we = 1'b1; i_dbg_addr = a; i_dbg_data = d;
    @(posedge i_clk); #1;
    i_dbg_we = 1'b0;
    mem_m[int'(a) % DEPTH] = d;
  endtask

  // Full transaction up to the last data nibble; cs_n is left low.
  task automatic txn(input logic [7:0] cmd, input logic [15:0] a, input int nnib,
                     input bit dbg_noise);
    logic [7:0] b;
    logic [3:0] e;
    step(1'b0, cmd[7:4]);
    chk("cmd_busy", 8'(o_busy), 8'd1);
    chk("cmd_oe", 8'(o_sqi_oe), 8'd0);
    step(1'b0, cmd[3:0]);
    chk("cmd_oe", 8'(o_sqi_oe), 8'd0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, a[i*4 +: 4]);
      if (!(cmd == 8'h03 && i == 0)) chk("addr_oe", 8'(o_sqi_oe), 8'd0);
    end
    if (cmd == 8'h03) begin
      chk("addr_oe", 8'(o_sqi_oe), 8'd0);
      step(1'b0, 4'($urandom));
      chk("dummy_oe", 8'(o_sqi_oe), 8'd0);
      step(1'b0, 4'($urandom));
      for (int j = 0; j < nnib; j++) begin
        b = mem_m[(int'(a) + j / 2) % DEPTH];
        e = (j % 2 == 0) ? b[7:4] : b[3:0];
        chk("rd_oe", 8'(o_sqi_oe), 8'd1);
        chk("rd_nib", 8'(o_sqi_sio), 8'(e));
        if (j < nnib - 1) step(1'b0, 4'($urandom));
      end
    end else if (cmd == 8'h02) begin
      for (int j = 0; j < nnib; j++) begin
        if (dbg_noise) begin
          i_dbg_we = 1'b1; i_dbg_addr = 16'($urandom); i_dbg_data = 8'($urandom);
        end
        step(1'b0, dat[j]);
        chk("wr_oe", 8'(o_sqi_oe), 8'd0);
        if (j % 2 == 1) mem_m[(int'(a) + j / 2) % DEPTH] = {dat[j-1], dat[j]};
      end
      i_dbg_we = 1'b0;
    end else begin
      for (int j = 0; j < nnib; j++) begin
        step(1'b0, 4'($urandom));
        chk("ign_oe", 8'(o_sqi_oe), 8'd0);
      end
    end
  endtask

  task automatic end_txn();
    i_sqi_cs_n = 1'b1; i_dbg_we = 1'b0;
    #1;
    chk("cs_gate_oe", 8'(o_sqi_oe), 8'd0);
    @(posedge i_clk); #1;
    chk("idle_busy", 8'(o_busy), 8'd0);
    chk("idle_sio", 8'(o_sqi_sio), 8'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, expected $finish before 300us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cmd;
    logic [15:0] a;
    int r, n;
    i_rst_n = 1'b0; i_sqi_cs_n = 1'b1; i_sqi_sio = '0;
    i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_data = '0;
    #12;
    chk("rst_busy", 8'(o_busy), 8'd0);
    chk("rst_oe", 8'(o_sqi_oe), 8'd0);
    chk("rst_sio", 8'(o_sqi_sio), 8'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Preload every byte, with random upper address bits that must be ignored.
    for (int i = 0; i < DEPTH; i++)
      bd(16'(($urandom & ~(DEPTH - 1)) | i), 8'($urandom));
    bd(16'h0010, 8'hA5);
    bd(16'h0011, 8'h3C);

    txn(8'h03, 16'h0010, 4, 1'b0);
    end_txn();

    dat[0] = 4'h1; dat[1] = 4'h2; dat[2] = 4'h3; dat[3] = 4'h4;
    txn(8'h02, 16'h0200, 4, 1'b0);
    end_txn();
    txn(8'h03, 16'h0200, 4, 1'b0);
    end_txn();

    bd(16'h00FF, 8'h11);
    bd(16'h0000, 8'h22);
    txn(8'h03, 16'h01FF, 4, 1'b0);
    end_txn();

    dat[0] = 4'h7; dat[1] = 4'h8; dat[2] = 4'h9;
    txn(8'h02, 16'h0040, 3, 1'b0);
    end_txn();
    txn(8'h03, 16'h0040, 4, 1'b0);
    end_txn();

    txn(8'h03, 16'h0010, 3, 1'b0);
    end_txn();
    txn(8'h03, 16'h0011, 4, 1'b0);
    end_txn();

    txn(8'hFF, 16'($urandom), 12, 1'b0);
    end_txn();

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      a = 16'($urandom);
      n = $urandom_range(1, 12);
      if (r < 4) cmd = 8'h03;
      else if (r < 8) cmd = 8'h02;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'hA7;
      end
      for (int j = 0; j < n; j++) dat[j] = 4'($urandom);
      txn(cmd, a, n, 1'b1);
      end_txn();
    end

    // Asynchronous reset in the read data phase, checked between clock edges.
    txn(8'h03, 16'h0080, 3, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("arst_oe", 8'(o_sqi_oe), 8'd0);
    chk("arst_busy", 8'(o_busy), 8'd0);
    chk("arst_sio", 8'(o_sqi_sio), 8'd0);
    i_sqi_cs_n = 1'b1;
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    txn(8'h03, 16'h0000, 2 * DEPTH, 1'b0);
    end_txn();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
Name: idli_sqi_mem_m

Overview:
- SQI (quad-SPI) responder: the memory end of the core's SQI initiator interface, emulating a 23LC-style serial SRAM in quad sequential mode.
- Used as the program/data memory in simulation and FPGA builds, connected directly to the core's SQI pins.
- SQI clock is i_clk: one nibble is transferred per i_clk cycle while chip select is low.

Parameters:
- DEPTH, 65536, memory size in bytes; power of two, 2..65536.
- ADDR_W, 16, address nibbles × 4; fixed by protocol, not overridable.

Ports:
- i_clk  in  1  core clock, also the SQI clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sqi_cs_n  in  1  chip select, active low.
- i_sqi_sio  in  4  nibble from initiator.
- o_sqi_sio  out  4  nibble to initiator; valid only when o_sqi_oe is high.
- o_sqi_oe  out  1  output enable for o_sqi_sio.
- i_dbg_we  in  1  backdoor byte write, for preload; ignored while i_sqi_cs_n is low.
- i_dbg_addr  in  16  backdoor byte address.
- i_dbg_data  in  8  backdoor byte data.
- o_busy  out  1  high while a transaction is in progress (state != IDLE).

Behaviour:
- Reset: state IDLE; o_sqi_sio = 0, o_sqi_oe = 0, o_busy = 0. Address and shift registers are cleared. Memory contents are not reset.
- Nibble order: most significant nibble first for command, address and data bytes. Byte addressing.
- Cycle k counts rising edges sampled with i_sqi_cs_n = 0; k = 0 is the first such edge.
- k = 0..1: command byte. 0x03 selects READ, 0x02 selects WRITE, any other value selects IGNORE.
- k = 2..5: 16-bit address, MSB nibble first. Bits above log2(DEPTH) are ignored.
- READ:
  - k = 6..7: dummy nibbles; input is ignored.
  - From the cycle after edge k = 7, o_sqi_oe = 1 and o_sqi_sio presents the high nibble of mem[addr].
  - Each subsequent edge advances one nibble: high, low, then the next byte.
  - Address increments after each low nibble.
- WRITE:
  - From k = 6, nibbles are collected in pairs (high, then low).
  - The byte is written to mem[addr] on the low-nibble edge, then the address increments.
- IGNORE: the block consumes and ignores all input until i_sqi_cs_n rises. o_sqi_oe stays 0.
- Address wrap: the address is computed modulo DEPTH, so DEPTH-1 is followed by 0. This applies to both reads and writes.
- Chip select rising at any point:
  - State returns to IDLE on that edge.
  - o_sqi_oe is gated combinationally with ~i_sqi_cs_n, so it drops in the same cycle with no bus contention.
  - A half-collected write byte is discarded; completed bytes are kept.
- Back-to-back transactions: cs_n high for a single cycle is a sufficient gap. The next low cycle is k = 0.
- Reset asserted mid-transaction: immediate return to IDLE with outputs at their reset values. A half-collected byte is not written.
- Backdoor write and SQI write in the same cycle: the SQI write wins, because i_dbg_we is ignored while cs_n is low.
- Read-after-write: a READ issued after a WRITE transaction ends returns the new data. There is no hazard inside one transaction because the transaction is either a read or a write.
- o_busy = (state != IDLE).

State machine (idli_pkg::sqi_state_t):
- IDLE → CMD when cs_n is low.
- CMD → ADDR after 2 nibbles.
- ADDR → DUMMY (READ), WDATA (WRITE) or SKIP (other) after 4 nibbles.
- DUMMY → RDATA after 2 nibbles.
- RDATA, WDATA and SKIP are held until cs_n rises.
- Any state → IDLE when cs_n is high.
- A 2-bit nibble counter (idli_pkg::ctr_t) tracks position within each phase.

Decomposition:
- Add to idli_pkg:
  - sqi_cmd_t: SQI_CMD_WRITE = 8'h02, SQI_CMD_READ = 8'h03.
  - sqi_state_t: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, SKIP.
  - localparam SQI_DUMMY_NIBBLES = 2.
- Reuse slice_t for nibbles.
- Sub-module idli_sqi_ram_m: byte-wide RAM, DEPTH entries, one write port (SQI or debug via mux) and one combinational read port. Keeps the FSM separate from the storage so it can be replaced by a vendor RAM.

Test Plan:
- Backdoor preload mem[0x0010] = 0xA5, mem[0x0011] = 0x3C; SQI READ 03,0010, 2 dummy nibbles, 4 data cycles → o_sqi_sio = A,5,3,C with oe = 1 from the cycle after k = 7; oe = 0 throughout k = 0..7.
- SQI WRITE 02,0200, nibbles 1,2,3,4 then cs_n high; then READ 0200 → 0x12, 0x34; o_sqi_oe stays 0 for the whole write.
- Wrap: DEPTH = 256, preload mem[0xFF] = 0x11, mem[0x00] = 0x22; READ from 0x01FF → 0x11 then 0x22.
- Abort: WRITE to 0x0040 with 3 data nibbles (7,8,9) then cs_n high → mem[0x40] = 0x78, mem[0x41] unchanged; o_busy drops on the same edge.
- Abort read: READ aborted mid-data (cs_n high) → o_sqi_oe is 0 in that same cycle; an immediate new READ after a 1-cycle gap returns correct data.
- Unknown command 0xFF followed by 12 nibbles → no memory change, oe always 0. Async reset during RDATA → oe = 0 and o_busy = 0 immediately, without waiting for a clock edge.
